// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, symbol codes
// and element lengths in Morse time units.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MARK   = 3'd3,
    ESPACE = 3'd4,
    CGAP   = 3'd5,
    WGAP   = 3'd6
  } state_e;

  localparam logic [1:0] SYM_DOT  = 2'b10;
  localparam logic [1:0] SYM_DASH = 2'b11;

  localparam int DOT_UNITS      = 1;
  localparam int DASH_UNITS     = 3;
  localparam int ELEM_GAP_UNITS = 1;

  // A symbol slot carries an element only when its upper bit is set.
  function automatic logic sym_is_element(input logic [1:0] sym);
    return sym[1];
  endfunction

endpackage

// File: rtl/morse_keyer_if.sv
// Character handshake between the character source and the Morse keyer.
interface morse_keyer_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  in_valid;
  logic [ADDR_WIDTH-1:0] in_char;
  logic                  in_ready;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/morse_table.sv
// ASCII to Morse code word lookup with a one-cycle registered read.
// Code words are MSB-first, 2 bits per symbol (10 dot, 11 dash, 0x terminator).
module morse_table #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] d_out
);

  // Codes are held left-aligned in 16 bits; unknown characters map to zero.
  function automatic logic [15:0] lookup(input logic [7:0] ch);
    logic [7:0] c;
    c = ch;
    if (c >= 8'h41 && c <= 8'h5A) c = c | 8'h20;
    case (c)
      8'h61: return 16'hB000; 8'h62: return 16'hEA00; 8'h63: return 16'hEE00;
      8'h64: return 16'hE800; 8'h65: return 16'h8000; 8'h66: return 16'hAE00;
      8'h67: return 16'hF800; 8'h68: return 16'hAA00; 8'h69: return 16'hA000;
      8'h6A: return 16'hBF00; 8'h6B: return 16'hEC00; 8'h6C: return 16'hBA00;
      8'h6D: return 16'hF000; 8'h6E: return 16'hE000; 8'h6F: return 16'hFC00;
      8'h70: return 16'hBE00; 8'h71: return 16'hFB00; 8'h72: return 16'hB800;
      8'h73: return 16'hA800; 8'h74: return 16'hC000; 8'h75: return 16'hAC00;
      8'h76: return 16'hAB00; 8'h77: return 16'hBC00; 8'h78: return 16'hEB00;
      8'h79: return 16'hEF00; 8'h7A: return 16'hFA00;
      8'h30: return 16'hFFC0; 8'h31: return 16'hBFC0; 8'h32: return 16'hAFC0;
      8'h33: return 16'hABC0; 8'h34: return 16'hAAC0; 8'h35: return 16'hAA80;
      8'h36: return 16'hEA80; 8'h37: return 16'hFA80; 8'h38: return 16'hFE80;
      8'h39: return 16'hFF80;
      default: return 16'h0000;
    endcase
  endfunction

  logic [15:0]              code16;
  logic [DATA_WIDTH+15:0]   code_wide;

  always_comb begin
    code16    = lookup(8'(addr));
    code_wide = {code16, {DATA_WIDTH{1'b0}}};
  end

  // Keep the top DATA_WIDTH bits so the first symbol always sits at the MSBs.
  always_ff @(posedge clk) begin
    d_out <= DATA_WIDTH'(code_wide >> 16);
  end

endmodule

// File: rtl/morse_keyer.sv
// Accepts ASCII characters and keys them out as timed Morse marks and gaps.
// key_out is registered from the next state so it tracks MARK exactly.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    UNIT_CYCLES    = 1000000,
  parameter int                    CHAR_GAP_UNITS = 3,
  parameter int                    WORD_GAP_UNITS = 7,
  parameter logic [ADDR_WIDTH-1:0] SPACE_CHAR     = 8'h20
) (
  input  logic          clk,
  input  logic          rst,
  morse_keyer_if.slave  in_if,
  output logic          key_out,
  output logic          busy,
  output logic          char_done,
  output logic          err
);

  localparam int CYC_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UNIT_W = $clog2(WORD_GAP_UNITS + 1);
  localparam int SYMS   = DATA_WIDTH / 2;
  localparam int SYM_W  = $clog2(SYMS + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);

  state_e                  state;
  state_e                  nxt;
  logic [ADDR_WIDTH-1:0]   char_reg;
  logic [DATA_WIDTH-1:0]   code_word;
  logic [DATA_WIDTH-1:0]   sreg;
  logic [DATA_WIDTH-1:0]   sreg_next_sym;
  logic                    word_loaded;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [UNIT_W-1:0]       unit_cnt;
  logic [SYM_W-1:0]        sym_cnt;
  logic [UNIT_W-1:0]       unit_target;
  logic                    unit_end;
  logic                    phase_done;
  logic                    more_syms;

  morse_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_table (
    .clk   (clk),
    .addr  (char_reg),
    .d_out (code_word)
  );

  assign in_if.in_ready = (state == IDLE) && !rst;
  assign busy           = (state != IDLE);

  always_comb begin
    unit_target = UNIT_W'(1);
    case (state)
      MARK:    unit_target = (sreg[DATA_WIDTH-1 -: 2] == SYM_DASH) ?
                             UNIT_W'(DASH_UNITS) : UNIT_W'(DOT_UNITS);
      ESPACE:  unit_target = UNIT_W'(ELEM_GAP_UNITS);
      CGAP:    unit_target = UNIT_W'(CHAR_GAP_UNITS);
      WGAP:    unit_target = UNIT_W'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
      default: unit_target = UNIT_W'(1);
    endcase
  end

  always_comb begin
    unit_end      = (cyc_cnt == CYC_LAST);
    phase_done    = unit_end && (unit_cnt == unit_target - UNIT_W'(1));
    sreg_next_sym = sreg << 2;
    more_syms     = ((int'(sym_cnt) + 1) < SYMS) &&
                    sym_is_element(sreg_next_sym[DATA_WIDTH-1 -: 2]);
  end

  // DECODE spends one cycle loading the shift register, then decides from it.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_if.in_valid) nxt = (in_if.in_char == SPACE_CHAR) ? WGAP : FETCH;
      FETCH:   nxt = DECODE;
      DECODE:  if (word_loaded) begin
                 if (sym_is_element(sreg[DATA_WIDTH-1 -: 2])) nxt = MARK;
                 else if (sreg == '0)                         nxt = IDLE;
                 else                                         nxt = CGAP;
               end
      MARK:    if (phase_done) nxt = more_syms ? ESPACE : CGAP;
      ESPACE:  if (phase_done) nxt = MARK;
      CGAP:    if (phase_done) nxt = IDLE;
      WGAP:    if (phase_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      char_reg    <= '0;
      sreg        <= '0;
      word_loaded <= 1'b0;
      cyc_cnt     <= '0;
      unit_cnt    <= '0;
      sym_cnt     <= '0;
      key_out     <= 1'b0;
      char_done   <= 1'b0;
      err         <= 1'b0;
    end else begin
      state     <= nxt;
      key_out   <= (nxt == MARK);
      char_done <= ((state == CGAP) || (state == WGAP)) && phase_done;
      err       <= (state == DECODE) && word_loaded && (sreg == '0);

      if (state == IDLE && in_if.in_valid) char_reg <= in_if.in_char;

      word_loaded <= (state == DECODE) && !word_loaded;
      if (state == DECODE && !word_loaded) sreg <= code_word;
      else if (state == MARK && phase_done) sreg <= sreg_next_sym;

      if (state == IDLE)                    sym_cnt <= '0;
      else if (state == MARK && phase_done) sym_cnt <= sym_cnt + 1'b1;

      // Every state entry restarts timing from zero so elements never drift.
      if (nxt != state) begin
        cyc_cnt  <= '0;
        unit_cnt <= '0;
      end else if (unit_end) begin
        cyc_cnt  <= '0;
        unit_cnt <= unit_cnt + 1'b1;
      end else begin
        cyc_cnt  <= cyc_cnt + 1'b1;
      end
    end
  end

endmodule
